// File: rtl/ccsds_pkg.sv
// Shared constants and types for the CCSDS pseudo-randomizer.
// Holds the h(x) tap mask, the default seed and the framing FSM states.
package ccsds_pkg;

    localparam int          LFSR_W       = 8;
    // Feedback taps of h(x)=x^8+x^7+x^5+x^3+1 as state bits 7,5,3,0
    localparam logic [7:0]  LFSR_TAPS    = 8'b1010_1001;
    localparam logic [7:0]  DEFAULT_SEED = 8'hFF;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_e;

    // One LFSR step: shift right, feedback enters at the top
    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] s
    );
        return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/ccsds_lfsr_step.sv
// Unrolled DATA_W-step LFSR advance with keystream output.
// Keystream MSB is the first emitted bit, matching transmit order.
module ccsds_lfsr_step
    import ccsds_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [LFSR_W-1:0] i_state,
    output logic [LFSR_W-1:0] o_next,
    output logic [DATA_W-1:0] o_keystream
);

    logic [LFSR_W-1:0] w_s;

    // Emit lfsr[0] then step, DATA_W times, MSB of the beat first
    always_comb begin
        w_s         = i_state;
        o_keystream = '0;
        for (int j = 0; j < DATA_W; j++) begin
            o_keystream[DATA_W-1-j] = w_s[0];
            w_s                     = lfsr_next(w_s);
        end
        o_next = w_s;
    end

endmodule

// File: rtl/ccsds_randomizer.sv
// CCSDS pseudo-randomizer with valid/ready streaming and per-frame seeding.
// One-beat registered output stage; LFSR only advances on accepted beats.
module ccsds_randomizer
    import ccsds_pkg::*;
#(
    parameter int          DATA_W = 8,
    parameter logic [7:0]  SEED   = DEFAULT_SEED
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              bypass_i,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_valid_i,
    input  logic              s_last_i,
    output logic              s_ready_o,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_valid_o,
    output logic              m_last_o,
    input  logic              m_ready_i,
    output logic [15:0]       frame_cnt_o
);

    state_e              r_state;
    logic [LFSR_W-1:0]   r_lfsr;
    logic                r_byp;
    logic [DATA_W-1:0]   r_data;
    logic                r_last;
    logic                r_valid;
    logic [15:0]         r_cnt;

    logic                w_accept;
    logic                w_start;
    logic                w_byp;
    logic                w_out_hs;
    logic [LFSR_W-1:0]   w_lfsr_in;
    logic [LFSR_W-1:0]   w_lfsr_nxt;
    logic [DATA_W-1:0]   w_ks;
    logic [DATA_W-1:0]   w_data;

    assign s_ready_o   = !r_valid || m_ready_i;
    assign w_accept    = s_valid_i && s_ready_o;
    assign w_out_hs    = r_valid && m_ready_i;

    // A beat seen in ST_IDLE opens a frame: reseed and sample bypass
    assign w_start     = (r_state == ST_IDLE);
    assign w_lfsr_in   = w_start ? SEED : r_lfsr;
    assign w_byp       = w_start ? bypass_i : r_byp;
    assign w_data      = w_byp ? s_data_i : (s_data_i ^ w_ks);

    assign m_data_o    = r_data;
    assign m_valid_o   = r_valid;
    assign m_last_o    = r_last;
    assign frame_cnt_o = r_cnt;

    ccsds_lfsr_step #(
        .DATA_W      (DATA_W)
    ) u_step (
        .i_state     (w_lfsr_in),
        .o_next      (w_lfsr_nxt),
        .o_keystream (w_ks)
    );

    // Framing FSM, LFSR state and registered output beat
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_lfsr  <= SEED;
            r_byp   <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else if (clear_i) begin
            r_state <= ST_IDLE;
            r_lfsr  <= SEED;
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_state <= s_last_i ? ST_IDLE : ST_FRAME;
            r_lfsr  <= w_lfsr_nxt;
            r_byp   <= w_byp;
            r_data  <= w_data;
            r_last  <= s_last_i;
            r_valid <= 1'b1;
        end else if (m_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    // Completed-frame counter, bumped when the last beat leaves
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (w_out_hs && r_last) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_ccsds_randomizer.sv
// Scoreboard bench for ccsds_randomizer (8-bit and 1-bit instances).
// Stimulus pushes expected beats; negedge monitors pop and compare.
module tb_ccsds_randomizer;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        byp;
    logic [7:0]  sd;
    logic        sv;
    logic        sl;
    logic        sr;
    logic [7:0]  md;
    logic        mv;
    logic        ml;
    logic        mr;
    logic [15:0] fc;

    logic [0:0]  sd1;
    logic        sv1;
    logic        sl1;
    logic        sr1;
    logic [0:0]  md1;
    logic        mv1;
    logic        ml1;
    logic [15:0] fc1;
    logic        byp1 = 1'b0;
    logic        mr1 = 1'b1;

    exp_t q8[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ccsds_randomizer #(.DATA_W(8), .SEED(8'hFF)) u_dut8 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clr),
        .bypass_i    (byp),
        .s_data_i    (sd),
        .s_valid_i   (sv),
        .s_last_i    (sl),
        .s_ready_o   (sr),
        .m_data_o    (md),
        .m_valid_o   (mv),
        .m_last_o    (ml),
        .m_ready_i   (mr),
        .frame_cnt_o (fc)
    );

    ccsds_randomizer #(.DATA_W(1), .SEED(8'hFF)) u_dut1 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clr),
        .bypass_i    (byp1),
        .s_data_i    (sd1),
        .s_valid_i   (sv1),
        .s_last_i    (sl1),
        .s_ready_o   (sr1),
        .m_data_o    (md1),
        .m_valid_o   (mv1),
        .m_last_o    (ml1),
        .m_ready_i   (mr1),
        .frame_cnt_o (fc1)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && mv && mr) begin
            if (q8.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL m8_extra: got %h expected no beat", md);
            end else begin
                e = q8.pop_front();
                chk("m8_beat", {23'd0, ml, md}, {23'd0, e.l, e.d});
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && mv1 && mr1) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL m1_extra: got %h expected no beat", md1);
            end else begin
                e = q1.pop_front();
                if (e.c)
                    chk("m1_bit", {30'd0, ml1, md1}, {30'd0, e.l, e.d[0]});
            end
        end
    end

    task automatic beat(input logic [7:0] d, input logic l,
                        input logic [7:0] e);
        int n = 0;
        sd = d;
        sl = l;
        sv = 1'b1;
        @(negedge clk);
        while (!sr && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!sr) begin
            n_cmp++;
            n_bad++;
            $display("FAIL beat8_timeout: s_ready 0 expected 1");
        end else begin
            q8.push_back('{d: e, l: l, c: 1'b1});
        end
        @(posedge clk);
        #1;
        sv = 1'b0;
        sl = 1'b0;
    endtask

    task automatic beat1(input logic d, input logic l,
                         input logic e, input logic c);
        int n = 0;
        sd1 = d;
        sl1 = l;
        sv1 = 1'b1;
        @(negedge clk);
        while (!sr1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!sr1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL beat1_timeout: s_ready 0 expected 1");
        end else begin
            q1.push_back('{d: {7'd0, e}, l: l, c: c});
        end
        @(posedge clk);
        #1;
        sv1 = 1'b0;
        sl1 = 1'b0;
    endtask

    task automatic drain8(input logic [15:0] exp_cnt, input string nm);
        int n = 0;
        while (q8.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("q8_drain", q8.size(), 0);
        @(posedge clk);
        #1;
        chk(nm, {16'd0, fc}, {16'd0, exp_cnt});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ref_bits;
        rst_n = 1'b0;
        clr   = 1'b0;
        byp   = 1'b0;
        sd    = '0;
        sv    = 1'b0;
        sl    = 1'b0;
        mr    = 1'b1;
        sd1   = '0;
        sv1   = 1'b0;
        sl1   = 1'b0;
        #23;
        chk("rst_mvalid", {31'd0, mv}, 32'd0);
        chk("rst_mlast", {31'd0, ml}, 32'd0);
        chk("rst_mdata", {24'd0, md}, 32'd0);
        chk("rst_fcnt", {16'd0, fc}, 32'd0);
        chk("rst_sready", {31'd0, sr}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // zero frame
        beat(8'h00, 1'b0, 8'hFF);
        beat(8'h00, 1'b0, 8'h48);
        beat(8'h00, 1'b0, 8'h0E);
        beat(8'h00, 1'b1, 8'hC0);
        drain8(16'd1, "fcnt_t1");

        // ones frame then zero frame back-to-back
        beat(8'hFF, 1'b0, 8'h00);
        beat(8'hFF, 1'b0, 8'hB7);
        beat(8'hFF, 1'b0, 8'hF1);
        beat(8'hFF, 1'b1, 8'h3F);
        beat(8'h00, 1'b0, 8'hFF);
        beat(8'h00, 1'b0, 8'h48);
        beat(8'h00, 1'b0, 8'h0E);
        beat(8'h00, 1'b1, 8'hC0);
        drain8(16'd3, "fcnt_t2");

        // downstream stall for 3 cycles mid-frame
        beat(8'h00, 1'b0, 8'hFF);
        beat(8'h00, 1'b0, 8'h48);
        mr = 1'b0;
        fork
            beat(8'h00, 1'b0, 8'h0E);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_data", {24'd0, md}, 32'h48);
                    chk("stall_valid", {31'd0, mv}, 32'd1);
                    chk("stall_sready", {31'd0, sr}, 32'd0);
                end
                @(posedge clk);
                #1;
                mr = 1'b1;
            end
        join
        beat(8'h00, 1'b1, 8'hC0);
        drain8(16'd4, "fcnt_t3");

        // bypass frame with mid-frame toggling, then seeded frame
        byp = 1'b1;
        beat(8'hA5, 1'b0, 8'hA5);
        byp = 1'b0;
        beat(8'h3C, 1'b0, 8'h3C);
        byp = 1'b1;
        beat(8'h00, 1'b0, 8'h00);
        byp = 1'b0;
        beat(8'hFF, 1'b1, 8'hFF);
        beat(8'h00, 1'b0, 8'hFF);
        beat(8'h00, 1'b1, 8'h48);
        drain8(16'd6, "fcnt_t4");

        // asynchronous reset mid-frame
        beat(8'h00, 1'b0, 8'hFF);
        beat(8'h00, 1'b0, 8'h48);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mvalid", {31'd0, mv}, 32'd0);
        chk("arst_fcnt", {16'd0, fc}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("arst_mvalid2", {31'd0, mv}, 32'd0);
        beat(8'h00, 1'b1, 8'hFF);
        drain8(16'd1, "fcnt_t5");

        // soft clear overriding a simultaneous beat
        beat(8'h00, 1'b0, 8'hFF);
        beat(8'h00, 1'b0, 8'h48);
        clr = 1'b1;
        sv  = 1'b1;
        sd  = 8'h00;
        @(posedge clk);
        #1;
        clr = 1'b0;
        sv  = 1'b0;
        chk("clr_mvalid", {31'd0, mv}, 32'd0);
        beat(8'h00, 1'b1, 8'hFF);
        drain8(16'd2, "fcnt_t6");

        // 1-bit instance: 256-bit zero frame across the LFSR period
        ref_bits = 32'hFF48_0EC0;
        for (int k = 0; k < 256; k++) begin
            if (k < 32)
                beat1(1'b0, 1'b0, ref_bits[31-k], 1'b1);
            else if (k == 255)
                beat1(1'b0, 1'b1, 1'b1, 1'b1);
            else
                beat1(1'b0, 1'b0, 1'b0, 1'b0);
        end
        repeat (3) @(negedge clk);
        chk("q1_drain", q1.size(), 0);
        chk("fcnt_w1", {16'd0, fc1}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
